// File: rtl/uart_tx_arbiter.sv
// Wishbone master sharing one memory-mapped UART transmitter among N_REQ byte
// streams; grant is held per packet and the UART status is polled before each write.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter logic [63:0] UART_ADDRESS = 64'h1_0000_0000,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [8*N_REQ-1:0]   i_req_data,
    input  logic [N_REQ-1:0]     i_req_last,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_busy,
    output logic [63:0]          o_wb_adr,
    output logic [63:0]          o_wb_dat,
    output logic                 o_wb_we,
    output logic [7:0]           o_wb_sel,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    input  logic [63:0]          i_wb_dat,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_stall
);

    localparam int unsigned IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CIW = IW + 1;
    localparam int unsigned CW  = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, GAP} state_t;

    state_t           state_q;
    logic [IW-1:0]    owner_q;
    logic [IW-1:0]    rr_ptr_q;
    logic [IW-1:0]    rr_ptr_d;
    logic [N_REQ-1:0] grant_q;
    logic             locked_q;
    logic [CW-1:0]    to_cnt_q;
    logic [7:0]       byte_q;
    logic             last_q;

    logic             acc_found;
    logic [IW-1:0]    acc_idx;
    logic [N_REQ-1:0] acc_oh;
    logic [7:0]       acc_byte;
    logic             acc_last;
    logic [CIW-1:0]   cand;

    // Stall only stretches a phase (ack ends it); status bits above 0 are don't-care.
    logic unused_wb;
    assign unused_wb = ^{i_wb_stall, i_wb_dat[63:1]};

    always_comb begin
        acc_found = 1'b0;
        acc_idx   = '0;
        acc_oh    = '0;
        cand      = '0;
        if (state_q == IDLE && !i_reset) begin
            if (locked_q) begin
                acc_found = i_req_valid[owner_q];
                acc_idx   = owner_q;
            end else begin
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    cand = {1'b0, rr_ptr_q} + CIW'(i);
                    if (cand >= CIW'(N_REQ)) cand = cand - CIW'(N_REQ);
                    if (!acc_found && i_req_valid[cand[IW-1:0]]) begin
                        acc_found = 1'b1;
                        acc_idx   = cand[IW-1:0];
                    end
                end
            end
        end
        if (acc_found) acc_oh[acc_idx] = 1'b1;
    end

    assign acc_byte = i_req_data[8*acc_idx +: 8];
    assign acc_last = i_req_last[acc_idx];
    assign rr_ptr_d = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Ready and the accept-cycle grant are decoded from the IDLE state so the
    // byte is consumed in the cycle before the first status read strobe.
    assign o_req_ready = acc_oh;
    assign o_grant     = grant_q | acc_oh;
    assign o_busy      = (state_q != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            locked_q <= 1'b0;
            to_cnt_q <= '0;
            byte_q   <= '0;
            last_q   <= 1'b0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_we  <= 1'b0;
            o_wb_sel <= '0;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc_found) begin
                        owner_q  <= acc_idx;
                        grant_q  <= acc_oh;
                        byte_q   <= acc_byte;
                        last_q   <= acc_last;
                        to_cnt_q <= '0;
                        o_wb_adr <= UART_ADDRESS;
                        o_wb_sel <= 8'h01;
                        o_wb_we  <= 1'b0;
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        state_q  <= RD;
                    end else if (locked_q) begin
                        // Owner went quiet mid-packet: release after LOCK_TIMEOUT idle cycles.
                        if (to_cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                            to_cnt_q <= '0;
                            locked_q <= 1'b0;
                            rr_ptr_q <= rr_ptr_d;
                            grant_q  <= '0;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                end
                RD: begin
                    if (i_wb_ack) begin
                        if (i_wb_dat[0]) begin
                            o_wb_we  <= 1'b1;
                            o_wb_dat <= {56'h0, byte_q};
                            state_q  <= WR;
                        end else begin
                            o_wb_cyc <= 1'b0;
                            o_wb_stb <= 1'b0;
                            state_q  <= RD_GAP;
                        end
                    end
                end
                RD_GAP: begin
                    o_wb_cyc <= 1'b1;
                    o_wb_stb <= 1'b1;
                    state_q  <= RD;
                end
                WR: begin
                    if (i_wb_ack) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                        state_q  <= GAP;
                    end
                end
                GAP: begin
                    if (last_q) begin
                        locked_q <= 1'b0;
                        rr_ptr_q <= rr_ptr_d;
                        grant_q  <= '0;
                    end else begin
                        locked_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed bytes, a Wishbone
// slave model answers status reads and checks each UART write against expectations.
module tb_uart_tx_arbiter;

    localparam int          N    = 4;
    localparam int          LT   = 16;
    localparam logic [63:0] UART = 64'h1_0000_0000;

    logic           clk = 1'b0;
    logic           i_reset = 1'b1;
    logic [N-1:0]   i_req_valid = '0;
    logic [8*N-1:0] i_req_data = '0;
    logic [N-1:0]   i_req_last = '0;
    logic [N-1:0]   o_req_ready;
    logic [N-1:0]   o_grant;
    logic           o_busy;
    logic [63:0]    o_wb_adr;
    logic [63:0]    o_wb_dat;
    logic           o_wb_we;
    logic [7:0]     o_wb_sel;
    logic           o_wb_cyc;
    logic           o_wb_stb;
    logic [63:0]    i_wb_dat = '0;
    logic           i_wb_ack = 1'b0;
    logic           i_wb_stall = 1'b0;

    uart_tx_arbiter #(
        .N_REQ(N),
        .UART_ADDRESS(UART),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_last(i_req_last),
        .o_req_ready(o_req_ready), .o_grant(o_grant), .o_busy(o_busy),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n = 0;

    logic [8:0] src_q [N][$];
    logic [7:0] sb[$];
    int acc_log[$];
    int acc_cyc[$];
    int rd_cyc[$];
    int wr_cyc[$];
    logic [N-1:0] took = '0;

    int age = 0;
    int ack_delay = 0;
    int stall_cycles = 0;
    int busy_left = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Requester sources: drop the head once consumed, present the next byte.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (took[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            if (src_q[k].size() > 0) begin
                i_req_valid[k]       = 1'b1;
                i_req_data[8*k +: 8] = src_q[k][0][7:0];
                i_req_last[k]        = src_q[k][0][8];
            end else begin
                i_req_valid[k] = 1'b0;
            end
        end
    end

    // Wishbone slave model and monitor.
    always @(negedge clk) begin
        took = o_req_ready & i_req_valid;
        for (int k = 0; k < N; k++)
            if (o_req_ready[k]) begin
                acc_log.push_back(k);
                acc_cyc.push_back(cyc_n);
            end
        if (i_wb_ack || !o_wb_stb) age = 0;
        if (o_wb_stb && !i_reset) begin
            check_eq("stb_cyc", o_wb_cyc, 1);
            check_eq("stb_adr", o_wb_adr, UART);
            check_eq("stb_sel", o_wb_sel, 8'h01);
            if (o_wb_we && sb.size() > 0) check_eq("wr_dat", o_wb_dat, {56'h0, sb[0]});
            i_wb_stall = (age < stall_cycles);
            i_wb_ack   = (age >= ack_delay);
            i_wb_dat   = o_wb_we ? 64'h0 : {63'h0, busy_left == 0};
            if (i_wb_ack) begin
                if (o_wb_we) begin
                    wr_cyc.push_back(cyc_n);
                    check_eq("wr_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) void'(sb.pop_front());
                end else begin
                    rd_cyc.push_back(cyc_n);
                    if (busy_left > 0) busy_left--;
                end
            end
            age++;
        end else begin
            i_wb_ack   = 1'b0;
            i_wb_stall = 1'b0;
        end
    end

    task automatic load(input int k, input logic last, input logic [7:0] b);
        src_q[k].push_back({last, b});
        sb.push_back(b);
    endtask

    task automatic clear_logs();
        acc_log.delete(); acc_cyc.delete(); rd_cyc.delete(); wr_cyc.delete();
    endtask

    task automatic drain();
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            done = (sb.size() == 0) && (i_req_valid == '0) && !o_busy;
            for (int k = 0; k < N; k++) if (src_q[k].size() != 0) done = 1'b0;
        end
        check_eq("drain_done", done, 1);
    endtask

    task automatic check_resets(input string tag);
        check_eq({tag, "_cyc"}, o_wb_cyc, 0);
        check_eq({tag, "_stb"}, o_wb_stb, 0);
        check_eq({tag, "_we"}, o_wb_we, 0);
        check_eq({tag, "_adr"}, o_wb_adr, 0);
        check_eq({tag, "_dat"}, o_wb_dat, 0);
        check_eq({tag, "_sel"}, o_wb_sel, 0);
        check_eq({tag, "_ready"}, o_req_ready, 0);
        check_eq({tag, "_grant"}, o_grant, 0);
        check_eq({tag, "_busy"}, o_busy, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_resets("rst");
        i_reset = 1'b0;

        // Single byte, UART ready, immediate ack.
        clear_logs();
        load(0, 1'b1, 8'h41);
        drain();
        check_eq("t1_owner", qat(acc_log, 0), 0);
        check_eq("t1_reads", rd_cyc.size(), 1);
        check_eq("t1_writes", wr_cyc.size(), 1);
        check_eq("t1_rd_lat", qat(rd_cyc, 0) - qat(acc_cyc, 0), 1);
        check_eq("t1_wr_lat", qat(wr_cyc, 0) - qat(acc_cyc, 0), 2);
        check_eq("t1_grant_end", o_grant, 0);
        // Round-robin pointer now at 1: req1 beats req0.
        clear_logs();
        load(1, 1'b1, 8'h20);
        load(0, 1'b1, 8'h10);
        drain();
        check_eq("t1_rr_first", qat(acc_log, 0), 1);
        check_eq("t1_rr_second", qat(acc_log, 1), 0);

        // Busy polling: three not-ready reads before the UART goes idle.
        clear_logs();
        busy_left = 3;
        load(0, 1'b1, 8'h55);
        drain();
        check_eq("t2_reads", rd_cyc.size(), 4);
        check_eq("t2_writes", wr_cyc.size(), 1);
        for (int i = 1; i < 4; i++)
            check_eq("t2_poll_gap", qat(rd_cyc, i) - qat(rd_cyc, i - 1), 2);
        check_eq("t2_wr_after_rd", qat(wr_cyc, 0) - qat(rd_cyc, 3), 1);

        // Packet lock with competing requesters.
        clear_logs();
        load(1, 1'b0, 8'h61);
        load(1, 1'b1, 8'h62);
        load(2, 1'b1, 8'h32);
        load(0, 1'b1, 8'h30);
        drain();
        check_eq("t3_o0", qat(acc_log, 0), 1);
        check_eq("t3_o1", qat(acc_log, 1), 1);
        check_eq("t3_o2", qat(acc_log, 2), 2);
        check_eq("t3_o3", qat(acc_log, 3), 0);
        check_eq("t3_b2b_acc", qat(acc_cyc, 1) - qat(acc_cyc, 0), 4);
        check_eq("t3_b2b_wr", qat(wr_cyc, 1) - qat(wr_cyc, 0), 4);

        // Lock timeout: req3 leaves its packet open, req0 waits.
        clear_logs();
        load(3, 1'b0, 8'h77);
        load(0, 1'b1, 8'h78);
        n = 0;
        while (acc_log.size() < 1 && n < 200) begin @(negedge clk); n++; end
        check_eq("t4_first_acc", acc_log.size(), 1);
        repeat (8) @(negedge clk);
        check_eq("t4_lock_grant", o_grant, 4'b1000);
        check_eq("t4_lock_ready", o_req_ready, 0);
        check_eq("t4_lock_busy", o_busy, 0);
        drain();
        check_eq("t4_o0", qat(acc_log, 0), 3);
        check_eq("t4_o1", qat(acc_log, 1), 0);
        check_eq("t4_release", qat(acc_cyc, 1) - qat(acc_cyc, 0), LT + 4);

        // Stall for two cycles, ack on the fourth strobe cycle.
        clear_logs();
        stall_cycles = 2;
        ack_delay = 3;
        load(2, 1'b1, 8'h5A);
        drain();
        check_eq("t5_reads", rd_cyc.size(), 1);
        check_eq("t5_writes", wr_cyc.size(), 1);
        check_eq("t5_rd_lat", qat(rd_cyc, 0) - qat(acc_cyc, 0), 4);
        check_eq("t5_wr_lat", qat(wr_cyc, 0) - qat(rd_cyc, 0), 4);
        stall_cycles = 0;

        // Reset while the write strobe is up.
        clear_logs();
        ack_delay = 10;
        load(0, 1'b1, 8'h99);
        n = 0;
        while (!(o_wb_stb && o_wb_we) && n < 100) begin @(negedge clk); n++; end
        check_eq("t6_in_wr", o_wb_stb && o_wb_we, 1);
        i_reset = 1'b1;
        @(negedge clk);
        check_resets("t6_rst");
        i_reset = 1'b0;
        sb.delete();
        ack_delay = 0;
        clear_logs();
        load(0, 1'b1, 8'h42);
        drain();
        check_eq("t6_owner", qat(acc_log, 0), 0);
        check_eq("t6_writes", wr_cyc.size(), 1);
        check_eq("t6_wr_lat", qat(wr_cyc, 0) - qat(acc_cyc, 0), 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Wishbone bus master that shares the single memory-mapped UART transmitter among `N_REQ` byte-stream requesters (harts, debug monitor, boot console). It accepts one byte at a time from the granted requester and polls the UART status register until the transmitter is idle. It then writes the byte to the UART data register. Grant is held for a whole packet so lines from different requesters never interleave. Sits between the requesters and the system Wishbone interconnect, in front of the UART peripheral.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `UART_ADDRESS`, 64'h100000000: UART base address. Reads return bit 0 = 1 when the transmitter is idle. Writes of byte lane 0 start transmission.
- `LOCK_TIMEOUT`, 1024: idle cycles inside a packet before the lock is forcibly released, ≥ 2.
- `i_clk` in 1: the only clock. All logic on the rising edge.
- `i_reset` in 1: synchronous, active-high.
- `i_req_valid` in N_REQ: requester k has a byte.
- `i_req_data` in 8*N_REQ: byte of requester k in bits [8k+7:8k].
- `i_req_last` in N_REQ: the byte is the last of its packet.
- `o_req_ready` out N_REQ: one-cycle pulse; the byte of requester k is consumed this cycle.
- `o_grant` out N_REQ: one-hot current owner; 0 when unowned.
- `o_busy` out 1: FSM not in IDLE.
- `o_wb_adr` out 64, `o_wb_dat` out 64, `o_wb_we` out 1, `o_wb_sel` out 8, `o_wb_cyc` out 1, `o_wb_stb` out 1: Wishbone master outputs.
- `i_wb_dat` in 64, `i_wb_ack` in 1, `i_wb_stall` in 1: Wishbone master inputs.

## Operation
- FSM states are IDLE, RD, RD_GAP, WR and GAP.
- **IDLE**
  - Unlocked: grant the first requester with valid set, searching round-robin from the requester after the previous packet's owner (`rr_ptr`).
  - Locked: only the owner may be served.
  - On accept: pulse `o_req_ready[k]` and capture the byte and its `last` bit.
  - Go to RD.
- **RD**
  - Drive `cyc=stb=1`, `we=0`, `adr=UART_ADDRESS`, `sel=8'h01`.
  - On `i_wb_ack`: if `i_wb_dat[0]`=1 go to WR, else go to RD_GAP.
- **RD_GAP**: one cycle with `cyc=stb=0`, then back to RD.
- **WR**
  - Drive `cyc=stb=1`, `we=1`, `adr=UART_ADDRESS`, `sel=8'h01`, `dat={56'h0, byte}`.
  - On `i_wb_ack` go to GAP.
- **GAP**
  - One cycle with `cyc=stb=0`.
  - If the captured `last`=1: clear the lock, set `rr_ptr`=owner+1 (wrapping N_REQ-1 → 0), clear `o_grant`.
  - Otherwise: set the lock on the owner.
  - Go to IDLE.
- Bus rules:
  - `stb` stays asserted with constant address/data/we/sel until ack.
  - `i_wb_stall`=1 only extends the phase. An ack is accepted only in a cycle where `stb`=1.
  - Never more than one outstanding transfer.
- Lock timeout:
  - A counter runs in IDLE while locked and the owner's valid is 0. It clears on accept.
  - When it reaches LOCK_TIMEOUT, the lock is released and `rr_ptr` advances as on `last`.
- Non-owner valid requests while locked wait; they are never dropped.
- Requesters must hold data/last stable while valid and not ready.

## Timing
- Reset values:
  - `o_wb_cyc`, `o_wb_stb`, `o_wb_we` = 0; `o_wb_adr`, `o_wb_dat` = 0; `o_wb_sel` = 0.
  - `o_req_ready` = 0; `o_grant` = 0; `o_busy` = 0.
  - `rr_ptr` = 0; lock clear; timeout counter 0; state IDLE.
- Reset asserted mid-transfer drops `cyc`/`stb` on the next edge. No ready pulse is issued for the abandoned byte.
- Accept happens in the cycle with `o_req_ready`=1 (cycle 0). RD `stb` is high from cycle 1.
- Best case per byte, with ack in the first `stb` cycle and the UART ready:
  - accept (cycle 0), RD (cycle 1), WR (cycle 2), GAP (cycle 3).
  - The next accept can occur in cycle 4, so throughput is one byte per 4 cycles.
- Each not-ready poll adds an RD plus RD_GAP pair (2 cycles minimum).
- `o_grant` is valid from the accept cycle until GAP of the packet's last byte.
- `o_busy`=0 only in IDLE.

## Test plan
- Single byte: req0 sends 8'h41 with last=1, UART always ready, ack in the same cycle.
  - Expect: ready pulse in cycle 0, read at cycle 1, write with `dat`=64'h41 and `sel`=8'h01 at cycle 2.
  - Expect: `cyc` low at cycle 3, `o_grant`=0 and `rr_ptr`=1 afterwards.
- Busy polling: status returns bit0=0 for 3 reads, then 1.
  - Expect: exactly 4 reads separated by 1-cycle `cyc`-low gaps, then one write.
- Packet lock: req1 sends "ab" (last on b) while req0 and req2 are valid.
  - Expect: bytes 61, 62 written back-to-back for req1.
  - Expect: then req2, then req0 (round-robin from 2).
- Lock timeout: req3 sends one byte with last=0, then drops valid; req0 is valid.
  - Expect: req0 not granted until LOCK_TIMEOUT idle cycles elapse, then it is granted.
- Stall/slow ack: `i_wb_stall`=1 for 2 cycles and ack 3 cycles after `stb`.
  - Expect: address/data/we stable throughout, with a single write per byte.
- Reset during WR: assert `i_reset` while `stb`=1.
  - Expect: `cyc`/`stb`=0 next cycle and all outputs at reset values.
  - Expect: after release, a fresh request from req0 is served normally.
